// File: rtl/pattern_detector_param.sv
// Serial pattern detector with a run-time programmable pattern, length and overlap
// mode; registered one-cycle match pulse and a saturating match counter.
module pattern_detector_param #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  typedef enum logic [1:0] {UNCFG, FILL, ARMED} state_t;

  localparam logic [LW-1:0]    MAXL = LW'(MAX_LEN);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat, hist, hist_sh, mask;
  logic [LW-1:0]      len, fill, fill_inc, fill_d;
  logic               ovl, cfg_ok, take, match;

  // Datapath: match is judged on the post-shift history and fill.
  always_comb begin
    cfg_ok   = cfg_load && (cfg_len != '0) && (cfg_len <= MAXL);
    take     = in_valid && !cfg_load && (state_q != UNCFG);
    hist_sh  = {hist[MAX_LEN-2:0], in};
    fill_inc = (fill >= MAXL) ? MAXL : fill + LW'(1);
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (i < int'(len));
    match    = take && (fill_inc >= len) && (((hist_sh ^ pat) & mask) == '0);
    fill_d   = (match && !ovl) ? '0 : fill_inc;
  end

  always_comb begin
    state_d = state_q;
    if (cfg_ok)
      state_d = FILL;
    else if (take)
      state_d = (fill_d >= len) ? ARMED : FILL;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= UNCFG;
    else      state_q <= state_d;
  end

  // A rejected load touches nothing but cfg_err; any load drops a coincident bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out         <= 1'b0;
      cfg_err     <= 1'b0;
      match_count <= '0;
      hist        <= '0;
      fill        <= '0;
      pat         <= '0;
      len         <= '0;
      ovl         <= 1'b0;
    end else begin
      out     <= 1'b0;
      cfg_err <= cfg_load && !cfg_ok;
      if (cfg_ok) begin
        pat  <= cfg_pattern;
        len  <= cfg_len;
        ovl  <= cfg_overlap;
        hist <= '0;
        fill <= '0;
      end else if (take) begin
        hist <= hist_sh;
        fill <= fill_d;
        out  <= match;
        if (match && match_count != CMAX)
          match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed bench: stimulus pushes per-cycle expectations; a negedge monitor checks them.
module tb_pattern_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       m_valid = 1'b0, m_in = 1'b0, m_load = 1'b0, m_ovl = 1'b0;
  logic [7:0] m_pat = '0;
  logic [3:0] m_len = '0;
  logic       m_out, m_err;
  logic [7:0] m_cnt;

  logic       s_valid = 1'b0, s_in = 1'b0, s_load = 1'b0, s_ovl = 1'b0;
  logic [7:0] s_pat = '0;
  logic [3:0] s_len = '0;
  logic       s_out, s_err;
  logic [1:0] s_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit sel;
    bit o;
    int c;
    bit e;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pattern_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(m_valid), .in(m_in), .cfg_load(m_load),
    .cfg_pattern(m_pat), .cfg_len(m_len), .cfg_overlap(m_ovl),
    .out(m_out), .match_count(m_cnt), .cfg_err(m_err)
  );

  pattern_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in(s_in), .cfg_load(s_load),
    .cfg_pattern(s_pat), .cfg_len(s_len), .cfg_overlap(s_ovl),
    .out(s_out), .match_count(s_cnt), .cfg_err(s_err)
  );

  // Monitor: one expectation per clock edge, checked half a cycle later.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      logic o, e;
      int   c;
      x = sb.pop_front();
      o = x.sel ? s_out : m_out;
      e = x.sel ? s_err : m_err;
      c = x.sel ? int'(s_cnt) : int'(m_cnt);
      checks += 3;
      if (o !== x.o) begin
        errors++;
        $display("FAIL out[%0d] t=%0t got %b want %b", x.sel, $time, o, x.o);
      end
      if (c != x.c) begin
        errors++;
        $display("FAIL match_count[%0d] t=%0t got %0d want %0d", x.sel, $time, c, x.c);
      end
      if (e !== x.e) begin
        errors++;
        $display("FAIL cfg_err[%0d] t=%0t got %b want %b", x.sel, $time, e, x.e);
      end
    end
  end

  task automatic step(input bit sel, input bit r, input bit ld, input logic [7:0] p,
                      input int l, input bit ov, input bit v, input bit b,
                      input bit eo, input int ec, input bit ee);
    exp_t x;
    @(negedge clk);
    rst = r;
    if (sel) begin
      s_load = ld; s_pat = p; s_len = 4'(l); s_ovl = ov; s_valid = v; s_in = b;
    end else begin
      m_load = ld; m_pat = p; m_len = 4'(l); m_ovl = ov; m_valid = v; m_in = b;
    end
    @(posedge clk);
    x.sel = sel; x.o = eo; x.c = ec; x.e = ee;
    sb.push_back(x);
  endtask

  task automatic cfg(input bit sel, input logic [7:0] p, input int l, input bit ov,
                     input int ec, input bit ee);
    step(sel, 1'b1, 1'b1, p, l, ov, 1'b0, 1'b0, 1'b0, ec, ee);
  endtask

  task automatic bt(input bit sel, input bit v, input bit b, input bit eo, input int ec);
    step(sel, 1'b1, 1'b0, 8'h00, 0, 1'b0, v, b, eo, ec, 1'b0);
  endtask

  task automatic bits(input bit sel, input logic [7:0] v, input int n, input int ec);
    for (int i = n - 1; i >= 0; i--)
      bt(sel, 1'b1, v[i], 1'b0, ec);
  endtask

  initial begin
    // Reset state
    step(0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    // Unconfigured: data ignored
    bt(0, 1, 1, 0, 0); bt(0, 1, 1, 0, 0);

    // Legacy 10001, len 5, no overlap
    cfg(0, 8'h11, 5, 0, 0, 0);
    bits(0, 8'b0000_1000, 4, 0);
    bt(0, 1, 1, 1, 1);
    bt(0, 0, 0, 0, 1);

    // 101 overlap: pulses after bits 3 and 5
    cfg(0, 8'h05, 3, 1, 1, 0);
    bt(0, 1, 1, 0, 1); bt(0, 1, 0, 0, 1); bt(0, 1, 1, 1, 2);
    bt(0, 1, 0, 0, 2); bt(0, 1, 1, 1, 3);

    // 101 non-overlap: only after bit 3
    cfg(0, 8'h05, 3, 0, 3, 0);
    bt(0, 1, 1, 0, 3); bt(0, 1, 0, 0, 3); bt(0, 1, 1, 1, 4);
    bt(0, 1, 0, 0, 4); bt(0, 1, 1, 0, 4);

    // Bad configs after a good len-4 load; old pattern keeps working
    cfg(0, 8'h09, 4, 0, 4, 0);
    cfg(0, 8'hFF, 0, 1, 4, 1);
    cfg(0, 8'hFF, 9, 1, 4, 1);
    bt(0, 1, 1, 0, 4); bt(0, 1, 0, 0, 4); bt(0, 1, 0, 0, 4); bt(0, 1, 1, 1, 5);

    // Gaps of three idle cycles between bits of 1001
    bt(0, 1, 1, 0, 5);
    repeat (3) bt(0, 0, 1, 0, 5);
    bt(0, 1, 0, 0, 5);
    repeat (3) bt(0, 0, 1, 0, 5);
    bt(0, 1, 0, 0, 5);
    repeat (3) bt(0, 0, 1, 0, 5);
    bt(0, 1, 1, 1, 6);

    // Load coincident with a 1 bit: the bit is dropped
    step(0, 1'b1, 1'b1, 8'h09, 4, 1'b0, 1'b1, 1'b1, 1'b0, 6, 1'b0);
    bt(0, 1, 0, 0, 6); bt(0, 1, 0, 0, 6); bt(0, 1, 1, 0, 6);
    bt(0, 1, 0, 0, 6); bt(0, 1, 0, 0, 6); bt(0, 1, 1, 1, 7);

    // len 1, pattern 0
    cfg(0, 8'h00, 1, 0, 7, 0);
    bt(0, 1, 0, 1, 8); bt(0, 1, 1, 0, 8); bt(0, 1, 0, 1, 9);

    // Full-width pattern A5 (len = MAX_LEN)
    cfg(0, 8'hA5, 8, 1, 9, 0);
    bits(0, 8'b0101_0010, 7, 9);
    bt(0, 1, 1, 1, 10);

    // Reset mid-stream, then no pulse without a new load
    cfg(0, 8'h09, 4, 0, 10, 0);
    bt(0, 1, 1, 0, 10); bt(0, 1, 0, 0, 10); bt(0, 1, 0, 0, 10);
    step(0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    bt(0, 1, 1, 0, 0);
    bits(0, 8'b0000_1001, 4, 0);

    // Saturation with a 2-bit counter
    cfg(1, 8'h01, 1, 0, 0, 0);
    bt(1, 1, 1, 1, 1); bt(1, 1, 1, 1, 2); bt(1, 1, 1, 1, 3);
    bt(1, 1, 1, 1, 3); bt(1, 1, 1, 1, 3); bt(1, 1, 1, 1, 3);
    bt(1, 0, 0, 0, 3);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pattern_detector_param.md
PATTERN_DETECTOR_PARAM -- requirements
Module: pattern_detector_param

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, meaning the maximum pattern length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the match counter.
REQ-003 The block SHALL use the derived width LW = clog2(MAX_LEN+1) for length fields.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: `in` is sampled this cycle.
REQ-007 The block SHALL have port in, input, 1 bit: serial data bit.
REQ-008 The block SHALL have port cfg_load, input, 1 bit: load the configuration fields this cycle.
REQ-009 The block SHALL have port cfg_pattern, input, MAX_LEN bits: the pattern; bit [cfg_len-1] is the first bit received and bit [0] is the last.
REQ-010 The block SHALL have port cfg_len, input, LW bits: the pattern length.
REQ-011 The block SHALL have port cfg_overlap, input, 1 bit: 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-012 The block SHALL have port out, output, 1 bit: registered one-cycle match pulse.
REQ-013 The block SHALL have port match_count, output, CNT_W bits: saturating count of matches.
REQ-014 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse flagging a rejected cfg_load.

Function
REQ-015 The block SHALL hold the configuration registers pat, len and ovl, loaded only on cfg_load with 1 <= cfg_len <= MAX_LEN.
REQ-016 On cfg_load with cfg_len = 0 or cfg_len > MAX_LEN, the block SHALL pulse cfg_err for one cycle and leave the configuration, history and state unchanged.
REQ-017 An accepted cfg_load SHALL clear hist and fill, SHALL leave match_count unchanged, and SHALL move the FSM to FILL.
REQ-018 When cfg_load and in_valid are high together, cfg_load SHALL win and the data bit SHALL be dropped.
REQ-019 The FSM SHALL have exactly three states:
- UNCFG: entered from reset; in_valid is ignored and out = 0.
- FILL: fill < len.
- ARMED: fill >= len.
REQ-020 On in_valid in FILL or ARMED, the block SHALL update hist <= {hist[MAX_LEN-2:0], in} and fill <= min(fill+1, MAX_LEN).
REQ-021 A match SHALL be defined as fill_new >= len and hist_new[len-1:0] == pat[len-1:0], both evaluated on the post-shift values.
REQ-022 On a match, out SHALL be 1 in the cycle following the edge that sampled the final bit (latency 1 cycle); otherwise out SHALL be 0.
REQ-023 When in_valid is low, out SHALL be 0, and hist and fill SHALL hold; gaps in in_valid SHALL NOT break a partial match.
REQ-024 On a match with ovl = 0, fill SHALL be set to 0 (FSM to FILL) while hist still shifts; with ovl = 1, fill SHALL be updated per REQ-020.
REQ-025 On every match, match_count SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-026 A pattern of len = 1 SHALL match on every sampled bit equal to pat[0].

Reset
REQ-027 While rst = 0 at a rising clk edge, the block SHALL set: out = 0, cfg_err = 0, match_count = 0, hist = 0, fill = 0, pat = 0, len = 0, ovl = 0, FSM = UNCFG.
REQ-028 Reset asserted mid-stream SHALL discard any partial match; no out pulse SHALL occur until a new accepted cfg_load has been followed by a full pattern.
REQ-029 The block SHALL contain no asynchronous reset paths.

Verification
REQ-030 Legacy pattern: cfg_pattern = 5'b10001, len = 5, ovl = 0, bits 1,0,0,0,1 -> out = 1 exactly one cycle after the 5th bit; match_count = 1.
REQ-031 Overlap: pattern 3'b101, len = 3, stream 1,0,1,0,1:
- ovl = 1 -> pulses after bits 3 and 5; match_count = 2.
- ovl = 0 -> one pulse, after bit 3.
REQ-032 Bad configuration: after a valid load of len 4, cfg_load with cfg_len = 0 and then cfg_len = MAX_LEN+1 -> two cfg_err pulses; the old pattern still matches.
REQ-033 Saturation: CNT_W = 2, pattern len 1 = 1'b1, six 1-bits -> six out pulses; match_count sticks at 3.
REQ-034 Gaps and collision:
- Pattern 1001 with in_valid low for 3 cycles between each bit -> one match.
- cfg_load coincident with a bit -> that bit is ignored.
REQ-035 Reset mid-stream: after bits 1,0,0 of pattern 1001, pull rst low for 1 cycle, then send bit 1 -> no pulse; all outputs 0; FSM = UNCFG.
